// File: rtl/mem_write_arbiter_if.sv
// Requester-side bus of the mem-queue write arbiter: one lane per pipeline requester,
// packed lane-major (lane i occupies bits [i*W +: W] of each field).
interface mem_write_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_read_num;
  logic [256*NREQ-1:0] req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_nodata;
  logic [7*NREQ-1:0]   req_ret;

  // Handshake: lane i transfers on a rising clk edge where req_valid[i] && req_ready[i];
  // req_ready is combinational and one-hot, the requester holds its fields while valid.
  modport master (
    output req_valid, req_read_num, req_data, req_last, req_nodata, req_ret,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_read_num, req_data, req_last, req_nodata, req_ret,
    output req_ready
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter funnelling requester entries into the mem-queue write port,
// tracking a per-read slot pointer and reporting size/ret when a read closes.
module mem_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_SLOT = 101
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  mem_write_arbiter_if.slave bus,
  output logic               mem_we_1,
  output logic [7:0]         mem_read_num_1,
  output logic [6:0]         mem_addr_1,
  output logic [255:0]       mem_data_1,
  output logic               mem_size_valid,
  output logic [6:0]         mem_size,
  output logic [7:0]         mem_size_read_num,
  output logic               ret_valid,
  output logic [6:0]         ret,
  output logic [7:0]         ret_read_num,
  output logic               init_busy,
  output logic               overflow_err,
  output logic               o_dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_clr_cnt;
  logic [6:0]      r_ptr_tab [256];
  logic [IW-1:0]   r_rr_ptr;

  logic            w_allow;
  logic            w_found;
  logic            w_xfer;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW:0]     w_cand;
  logic [NREQ-1:0] w_ready;
  logic [7:0]      w_rd_num;
  logic [255:0]    w_data;
  logic [6:0]      w_ret;
  logic            w_last;
  logic            w_nodata;
  logic [6:0]      w_ptr_cur;
  logic            w_full;
  logic            w_do_write;
  logic            w_ovf_hit;
  logic            w_close;
  logic [6:0]      w_size;

  // Clear sequence: one table entry per cycle, restarted by any reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == 8'hFF) w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = ST_CLEAR;
    endcase
  end

  assign init_busy   = reset_n & (r_state == ST_CLEAR);
  assign o_dbg_state = r_state;
  assign w_allow     = reset_n & ~stall & (r_state == ST_RUN);

  // First valid lane at or after r_rr_ptr, scanning upward with wrap.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) w_cand = w_cand - (IW+1)'(NREQ);
      if (!w_found && bus.req_valid[w_cand[IW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[IW-1:0];
      end
    end
  end

  assign w_xfer = w_allow & w_found;

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_gnt_idx] = 1'b1;
  end

  assign bus.req_ready = w_ready;

  assign w_rd_num  = bus.req_read_num[w_gnt_idx*8 +: 8];
  assign w_data    = bus.req_data[w_gnt_idx*256 +: 256];
  assign w_ret     = bus.req_ret[w_gnt_idx*7 +: 7];
  assign w_last    = bus.req_last[w_gnt_idx];
  assign w_nodata  = bus.req_nodata[w_gnt_idx];

  // A full read keeps its pointer at MAX_SLOT, so the 7-bit increment never wraps.
  assign w_ptr_cur  = r_ptr_tab[w_rd_num];
  assign w_full     = (w_ptr_cur == 7'(MAX_SLOT));
  assign w_do_write = w_xfer & ~w_nodata & ~w_full;
  assign w_ovf_hit  = w_xfer & ~w_nodata & w_full;
  assign w_close    = w_xfer & w_last;
  assign w_size     = w_ptr_cur + {6'd0, w_do_write};

  always_ff @(posedge clk) begin
    if (reset_n && r_state == ST_CLEAR) r_ptr_tab[r_clr_cnt] <= '0;
    else if (w_close)                   r_ptr_tab[w_rd_num] <= '0;
    else if (w_do_write)                r_ptr_tab[w_rd_num] <= w_ptr_cur + 7'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we_1          <= 1'b0;
      mem_read_num_1    <= '0;
      mem_addr_1        <= '0;
      mem_data_1        <= '0;
      mem_size_valid    <= 1'b0;
      mem_size          <= '0;
      mem_size_read_num <= '0;
      ret_valid         <= 1'b0;
      ret               <= '0;
      ret_read_num      <= '0;
      overflow_err      <= 1'b0;
      r_rr_ptr          <= '0;
    end else begin
      mem_we_1       <= w_do_write;
      mem_size_valid <= w_close;
      ret_valid      <= w_close;
      if (w_do_write) begin
        mem_read_num_1 <= w_rd_num;
        mem_addr_1     <= w_ptr_cur;
        mem_data_1     <= w_data;
      end
      if (w_close) begin
        mem_size          <= w_size;
        mem_size_read_num <= w_rd_num;
        ret               <= w_ret;
        ret_read_num      <= w_rd_num;
      end
      if (w_ovf_hit) overflow_err <= 1'b1;
      if (w_xfer) r_rr_ptr <= (w_gnt_idx == IW'(NREQ-1)) ? '0 : w_gnt_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: a reference pointer model feeds expected
// writes/reports into queues that a negedge monitor drains against the DUT.
module tb_mem_write_arbiter;
  localparam int NREQ     = 4;
  localparam int MAX_SLOT = 101;

  logic         clk;
  logic         reset_n;
  logic         stall;
  logic         mem_we_1;
  logic [7:0]   mem_read_num_1;
  logic [6:0]   mem_addr_1;
  logic [255:0] mem_data_1;
  logic         mem_size_valid;
  logic [6:0]   mem_size;
  logic [7:0]   mem_size_read_num;
  logic         ret_valid;
  logic [6:0]   ret;
  logic [7:0]   ret_read_num;
  logic         init_busy;
  logic         overflow_err;
  logic         o_dbg_state;

  int checks;
  int errors;
  bit mon_en;
  bit exp_ovf;
  int mdl_ptr [256];

  logic [270:0] exp_wr_q[$];
  logic [29:0]  exp_sz_q[$];
  logic [270:0] exp_w;
  logic [29:0]  exp_s;

  mem_write_arbiter_if #(.NREQ(NREQ)) bus ();

  mem_write_arbiter #(.NREQ(NREQ), .MAX_SLOT(MAX_SLOT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall             (stall),
    .bus               (bus),
    .mem_we_1          (mem_we_1),
    .mem_read_num_1    (mem_read_num_1),
    .mem_addr_1        (mem_addr_1),
    .mem_data_1        (mem_data_1),
    .mem_size_valid    (mem_size_valid),
    .mem_size          (mem_size),
    .mem_size_read_num (mem_size_read_num),
    .ret_valid         (ret_valid),
    .ret               (ret),
    .ret_read_num      (ret_read_num),
    .init_busy         (init_busy),
    .overflow_err      (overflow_err),
    .o_dbg_state       (o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Driver tasks
  task automatic set_req(input int r, input logic [7:0] rn, input logic [255:0] d,
                         input bit lst, input bit nd, input logic [6:0] rv);
    bus.req_read_num[r*8 +: 8] = rn;
    bus.req_data[r*256 +: 256] = d;
    bus.req_ret[r*7 +: 7]      = rv;
    bus.req_last[r]            = lst;
    bus.req_nodata[r]          = nd;
  endtask

  task automatic model_xfer(input int r);
    logic [7:0]   rn;
    logic [255:0] d;
    logic [6:0]   rv;
    rn = bus.req_read_num[r*8 +: 8];
    d  = bus.req_data[r*256 +: 256];
    rv = bus.req_ret[r*7 +: 7];
    if (!bus.req_nodata[r]) begin
      if (mdl_ptr[rn] >= MAX_SLOT) exp_ovf = 1'b1;
      else begin
        exp_wr_q.push_back({rn, 7'(mdl_ptr[rn]), d});
        mdl_ptr[rn]++;
      end
    end
    if (bus.req_last[r]) begin
      exp_sz_q.push_back({rn, 7'(mdl_ptr[rn]), rn, rv});
      mdl_ptr[rn] = 0;
    end
  endtask

  task automatic send(input int r, input logic [7:0] rn, input logic [255:0] d,
                      input bit lst, input bit nd, input logic [6:0] rv);
    int waited;
    waited = 0;
    set_req(r, rn, d, lst, nd, rv);
    bus.req_valid    = '0;
    bus.req_valid[r] = 1'b1;
    #1;
    while (bus.req_ready[r] !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("grant_wait", 272'(bus.req_ready[r]), 272'(1));
    if (bus.req_ready[r] === 1'b1) model_xfer(r);
    @(posedge clk);
    #1;
  endtask

  task automatic grant_step(input int g);
    logic [NREQ-1:0] oh;
    oh = 4'b0001 << g;
    #1;
    check("grant_order", 272'(bus.req_ready), 272'(oh));
    if (bus.req_ready === oh) model_xfer(g);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_nodata = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    int bad_ready;
    cnt       = 0;
    bad_ready = 0;
    #1;
    while (init_busy === 1'b1 && cnt < 300) begin
      if (bus.req_ready !== '0) bad_ready++;
      cnt++;
      @(posedge clk);
      #2;
    end
    check({tag, "_busy_len"}, 272'(cnt), 272'(256));
    check({tag, "_ready_busy"}, 272'(bad_ready), 272'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 272'(bus.req_ready), 272'(0));
    check({tag, "_we"}, 272'(mem_we_1), 272'(0));
    check({tag, "_size_valid"}, 272'(mem_size_valid), 272'(0));
    check({tag, "_ret_valid"}, 272'(ret_valid), 272'(0));
    check({tag, "_init_busy"}, 272'(init_busy), 272'(0));
    check({tag, "_ovf"}, 272'(overflow_err), 272'(0));
    check({tag, "_addr_data"}, {mem_addr_1, mem_data_1}, 272'(0));
    check({tag, "_size_ret"}, {mem_size, ret, mem_size_read_num, ret_read_num}, 272'(0));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we_1 === 1'b1) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 272'(mem_we_1), 272'(0));
        else begin
          exp_w = exp_wr_q.pop_front();
          check("write", {mem_read_num_1, mem_addr_1, mem_data_1}, 272'(exp_w));
        end
      end
      if (mem_size_valid !== 1'b0 || ret_valid !== 1'b0) begin
        if (exp_sz_q.size() == 0) check("unexpected_report", 272'({mem_size_valid, ret_valid}), 272'(0));
        else begin
          exp_s = exp_sz_q.pop_front();
          check("report", 272'({mem_size_valid, ret_valid, mem_size_read_num, mem_size, ret_read_num, ret}),
                272'({2'b11, exp_s}));
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    mon_en  = 1'b0;
    exp_ovf = 1'b0;
    foreach (mdl_ptr[i]) mdl_ptr[i] = 0;
    reset_n          = 1'b0;
    stall            = 1'b0;
    bus.req_valid    = '0;
    bus.req_read_num = '0;
    bus.req_data     = '0;
    bus.req_last     = '0;
    bus.req_nodata   = '0;
    bus.req_ret      = '0;

    // Reset with every requester valid, then release and time the clear
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(20 + i), rand256(), 1'b0, 1'b0, 7'd0);
    bus.req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_clear("clr0");
    for (int s = 0; s < 8; s++) grant_step(s % NREQ);
    idle(2);

    // Three-entry read 5 from requester 2, closing with ret 9
    send(2, 8'd5, rand256(), 1'b0, 1'b0, 7'd0);
    send(2, 8'd5, rand256(), 1'b0, 1'b0, 7'd0);
    send(2, 8'd5, rand256(), 1'b1, 1'b0, 7'd9);
    idle(2);

    // Move rr_ptr to 1, then requesters 0 and 3 contend; stall for two cycles
    send(0, 8'd30, rand256(), 1'b0, 1'b0, 7'd0);
    set_req(0, 8'd31, rand256(), 1'b0, 1'b0, 7'd0);
    set_req(3, 8'd33, rand256(), 1'b0, 1'b0, 7'd0);
    bus.req_valid = 4'b1001;
    grant_step(3);
    grant_step(0);
    grant_step(3);
    grant_step(0);
    stall = 1'b1;
    #1;
    check("stall_ready_a", 272'(bus.req_ready), 272'(0));
    @(posedge clk);
    #2;
    check("stall_ready_b", 272'(bus.req_ready), 272'(0));
    check("stall_we", 272'(mem_we_1), 272'(0));
    @(posedge clk);
    #1;
    stall = 1'b0;
    grant_step(3);
    grant_step(0);
    idle(2);

    // Empty read closed by nodata+last; nodata without last is discarded
    send(1, 8'd40, 256'd0, 1'b1, 1'b1, 7'd17);
    send(1, 8'd41, rand256(), 1'b0, 1'b1, 7'd0);
    send(1, 8'd41, rand256(), 1'b1, 1'b0, 7'd3);
    idle(2);

    // Overflow: 102 entries to read 7, then close
    for (int n = 0; n < MAX_SLOT; n++) send(0, 8'd7, rand256(), 1'b0, 1'b0, 7'd0);
    #1;
    check("ovf_before", 272'(overflow_err), 272'(exp_ovf));
    send(0, 8'd7, rand256(), 1'b0, 1'b0, 7'd0);
    #1;
    check("ovf_after", 272'(overflow_err), 272'(exp_ovf));
    send(0, 8'd7, 256'd0, 1'b1, 1'b1, 7'd5);
    idle(2);

    // Reset in the middle of a read-3 sequence, and again in the middle of the clear
    send(3, 8'd3, rand256(), 1'b0, 1'b0, 7'd0);
    send(3, 8'd3, rand256(), 1'b0, 1'b0, 7'd0);
    reset_n = 1'b0;
    #1;
    check("rst_gate_ready", 272'(bus.req_ready), 272'(0));
    @(posedge clk);
    #1;
    check_reset_outputs("rst1");
    bus.req_valid = '0;
    foreach (mdl_ptr[i]) mdl_ptr[i] = 0;
    exp_ovf = 1'b0;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midclear_busy", 272'(init_busy), 272'(0));
    reset_n = 1'b1;
    wait_clear("clr2");
    send(3, 8'd3, rand256(), 1'b0, 1'b0, 7'd0);
    send(3, 8'd3, rand256(), 1'b1, 1'b0, 7'd11);
    idle(3);

    // Final report
    check("wr_q_drained", 272'(exp_wr_q.size()), 272'(0));
    check("sz_q_drained", 272'(exp_sz_q.size()), 272'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of pipeline requesters sharing the mem-queue write port.
REQ-002 Parameter: MAX_SLOT, default 101, mem slots per read.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  downstream stall; no grant while high.
REQ-006 req_valid  in  NREQ  per-requester entry valid.
REQ-007 req_ready  out  NREQ  one-hot grant, combinational.
REQ-008 req_read_num  in  8*NREQ  read number per requester.
REQ-009 req_data  in  256*NREQ  mem entry, layout [p_info, p_x2, p_x1, p_x0].
REQ-010 req_last  in  NREQ  entry closes its read.
REQ-011 req_nodata  in  NREQ  close-only; no data written (valid only with req_last).
REQ-012 req_ret  in  7*NREQ  ret value for the read, sampled with req_last.
REQ-013 mem_we_1, mem_read_num_1[7:0], mem_addr_1[6:0], mem_data_1[255:0]  out  write port to the mem queue.
REQ-014 mem_size_valid, mem_size[6:0], mem_size_read_num[7:0]  out  per-read size report.
REQ-015 ret_valid, ret[6:0], ret_read_num[7:0]  out  per-read ret report.
REQ-016 init_busy  out  1  slot-pointer table clear in progress.
REQ-017 overflow_err  out  1  sticky slot-overflow flag.

Function
REQ-018 The block SHALL hold a 256-entry x 7-bit slot-pointer table indexed by read number.
REQ-019 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
REQ-020 req_ready SHALL be all-zero when stall, init_busy or reset_n is low-active.
REQ-021 Otherwise req_ready SHALL be one-hot to the first valid requester at or after rr_ptr, ascending, wrapping modulo NREQ.
REQ-022 After a transfer by requester i, rr_ptr SHALL become (i+1) mod NREQ; otherwise it SHALL hold.
REQ-023 All port outputs SHALL be registered; latency from transfer to mem_we_1/mem_size_valid/ret_valid is 1 cycle.
REQ-024 Data transfer: mem_we_1=1, mem_addr_1=ptr[read_num], mem_read_num_1=read_num, mem_data_1=req_data; ptr[read_num] increments.
REQ-025 Non-transfer cycles: mem_we_1, mem_size_valid and ret_valid SHALL be 0; the data/address outputs hold.
REQ-026 req_last with data: the write SHALL occur, then mem_size=ptr+1, mem_size_valid=1, ret_valid=1, ret=req_ret, and ptr resets to 0.
REQ-027 req_last with req_nodata: no write; mem_size=ptr, mem_size_valid=1, ret_valid=1, ptr resets to 0.
REQ-028 req_nodata without req_last: the transfer SHALL be accepted and discarded.
REQ-029 Overflow: a data transfer with ptr==MAX_SLOT SHALL suppress mem_we_1, set overflow_err and leave ptr unchanged; a req_last still reports mem_size=MAX_SLOT.
REQ-030 The pointer update SHALL complete in the transfer cycle, so a back-to-back transfer to the same read uses the updated pointer.
REQ-031 Pointer arithmetic SHALL be 7-bit unsigned; it never wraps because of REQ-029.

Reset
REQ-032 While reset_n is low, all outputs SHALL be 0, rr_ptr=0 and overflow_err=0.
REQ-033 From the first cycle after reset_n goes high, init_busy SHALL be 1 for exactly 256 cycles, clearing one table entry per cycle (index 0..255), then drop to 0.
REQ-034 A reset asserted mid-operation or mid-clear SHALL abort all activity and restart the clear sequence.

Verification
REQ-035 Release reset with all req_valid high -> req_ready=0 for 256 cycles, init_busy falls, then the grant order is 0,1,2,3,0,...
REQ-036 Requester 2 sends 3 entries for read 5, the last with req_last and ret=9 -> writes at addr 0,1,2; then mem_size=3, mem_size_read_num=5, ret=9.
REQ-037 Requesters 0 and 3 are continuously valid with rr_ptr=1 -> 3 is granted, then 0, alternating; stall=1 for 2 cycles -> no grants and mem_we_1=0.
REQ-038 A read with 0 entries gets req_last+req_nodata -> mem_we_1=0, mem_size=0, ret_valid=1.
REQ-039 102 data entries to read 7 -> 101 writes at addr 0..100; the 102nd is suppressed with overflow_err=1; a closing req_last+req_nodata reports mem_size=101.
REQ-040 reset_n is pulsed low during a read-3 sequence -> outputs clear, the clear restarts, and the next read-3 write uses addr 0.
